// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, issues one outstanding imem
// request at a time, holds each instruction for decode and applies redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_kill, w_kill_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic [31:0] r_if_instr, w_if_instr_nxt;
  logic        r_fault, w_fault_nxt;
  logic [31:0] r_fault_pc, w_fault_pc_nxt;
  logic        w_misalign;
  logic        w_redir_ok;

  assign w_misalign = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign w_redir_ok = redirect_valid && (redirect_target[1:0] == 2'b00);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_kill_nxt     = r_kill;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_fault_nxt    = r_fault;
    w_fault_pc_nxt = r_fault_pc;
    // A misaligned redirect traps from any state and abandons any pending response
    if (w_misalign) begin
      w_state_nxt    = S_FAULT;
      w_fault_nxt    = 1'b1;
      w_fault_pc_nxt = redirect_target;
      w_kill_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_REQ;
          if (w_redir_ok) w_pc_nxt = redirect_target;
        end
        S_REQ: begin
          if (w_redir_ok) w_pc_nxt = redirect_target;
          if (imem_gnt) begin
            w_state_nxt = S_WAIT;
            if (w_redir_ok) w_kill_nxt = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill || w_redir_ok) begin
              w_kill_nxt  = 1'b0;
              w_state_nxt = S_REQ;
              if (w_redir_ok) w_pc_nxt = redirect_target;
            end else begin
              w_if_instr_nxt = imem_rdata;
              w_if_pc_nxt    = r_pc;
              w_state_nxt    = S_HOLD;
            end
          end else if (w_redir_ok) begin
            w_kill_nxt = 1'b1;
            w_pc_nxt   = redirect_target;
          end
        end
        S_HOLD: begin
          if (w_redir_ok) begin
            w_pc_nxt    = redirect_target;
            w_state_nxt = S_REQ;
          end else if (if_ready) begin
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = S_REQ;
          end
        end
        S_FAULT: begin
          if (w_redir_ok) begin
            w_pc_nxt    = redirect_target;
            w_fault_nxt = 1'b0;
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_if_pc    <= RESET_PC;
      r_if_instr <= 32'h0;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_fault    <= w_fault_nxt;
      r_fault_pc <= w_fault_pc_nxt;
    end
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign if_valid  = (r_state == S_HOLD);
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, reset corner cases, a
// randomized run against a transaction-level PC model, and a wrap-around case.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        fault;
  logic [31:0] fault_pc;

  logic        rst2, rv2, gnt2, rvalid2, rdy2;
  logic [31:0] tgt2, rdata2;
  logic        req2, ifv2, fault2;
  logic [31:0] addr2, ifpc2, instr2, fpc2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .fault(fault), .fault_pc(fault_pc)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2),
    .redirect_valid(rv2), .redirect_target(tgt2),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .if_valid(ifv2), .if_pc(ifpc2), .if_instr(instr2), .if_ready(rdy2),
    .fault(fault2), .fault_pc(fpc2)
  );

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        gnt;
    logic        rvl;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_flt;
    logic [31:0] e_fpc;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t v(input logic rv, input logic [31:0] tgt, input logic gnt,
                             input logic rvl, input logic [31:0] rd, input logic rdy,
                             input logic e_req, input logic [31:0] e_addr, input logic e_ifv,
                             input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic e_flt, input logic [31:0] e_fpc);
    vec_t r;
    r.rv = rv; r.tgt = tgt; r.gnt = gnt; r.rvl = rvl; r.rd = rd; r.rdy = rdy;
    r.e_req = e_req; r.e_addr = e_addr; r.e_ifv = e_ifv; r.e_pc = e_pc;
    r.e_instr = e_instr; r.e_flt = e_flt; r.e_fpc = e_fpc;
    return r;
  endfunction

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_ifv"},   {31'd0, if_valid}, 32'd0);
    chk({tag, "_ifpc"},  if_pc, 32'h0);
    chk({tag, "_instr"}, if_instr, 32'h0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_fpc"},   fault_pc, 32'h0);
  endtask

  task automatic drive_idle();
    redirect_valid = 1'b0; redirect_target = 32'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
  endtask

  localparam logic [31:0] A0 = 32'h1111_0000, A4 = 32'h1111_0004, A8 = 32'h1111_0008;
  localparam logic [31:0] B0 = 32'h2222_0100, C0 = 32'h3333_0200, JNK = 32'hDEAD_BEEF;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    logic [31:0] exp_pc;
    int          ntx;
    logic        xfer;

    rst = 1'b1; rst2 = 1'b1;
    rv2 = 1'b0; tgt2 = 32'h0; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = 32'h0; rdy2 = 1'b0;
    drive_idle();

    //      rv  tgt         gnt rvl rd   rdy  req addr        ifv pc          instr flt fpc
    tbl[0]  = v(0, 32'h0,   0, 0, 32'h0, 0,  0, 32'h0,   0, 32'h0,   32'h0, 0, 32'h0);
    tbl[1]  = v(0, 32'h0,   1, 0, 32'h0, 0,  1, 32'h0,   0, 32'h0,   32'h0, 0, 32'h0);
    tbl[2]  = v(0, 32'h0,   0, 1, A0,    0,  0, 32'h0,   0, 32'h0,   32'h0, 0, 32'h0);
    tbl[3]  = v(0, 32'h0,   0, 0, 32'h0, 1,  0, 32'h0,   1, 32'h0,   A0,    0, 32'h0);
    for (int i = 4; i < 8; i++)
      tbl[i] = v(0, 32'h0,  0, 0, 32'h0, 0,  1, 32'h4,   0, 32'h0,   A0,    0, 32'h0);
    tbl[8]  = v(0, 32'h0,   1, 0, 32'h0, 0,  1, 32'h4,   0, 32'h0,   A0,    0, 32'h0);
    tbl[9]  = v(0, 32'h0,   0, 1, A4,    0,  0, 32'h4,   0, 32'h0,   A0,    0, 32'h0);
    tbl[10] = v(0, 32'h0,   0, 0, 32'h0, 1,  0, 32'h4,   1, 32'h4,   A4,    0, 32'h0);
    tbl[11] = v(0, 32'h0,   1, 0, 32'h0, 0,  1, 32'h8,   0, 32'h4,   A4,    0, 32'h0);
    tbl[12] = v(1, 32'h100, 0, 0, 32'h0, 0,  0, 32'h8,   0, 32'h4,   A4,    0, 32'h0);
    tbl[13] = v(0, 32'h0,   0, 1, A8,    0,  0, 32'h100, 0, 32'h4,   A4,    0, 32'h0);
    tbl[14] = v(0, 32'h0,   1, 0, 32'h0, 0,  1, 32'h100, 0, 32'h4,   A4,    0, 32'h0);
    tbl[15] = v(0, 32'h0,   0, 1, B0,    0,  0, 32'h100, 0, 32'h4,   A4,    0, 32'h0);
    for (int i = 16; i < 21; i++)
      tbl[i] = v(0, 32'h0,  0, (i == 17), JNK, 0, 0, 32'h100, 1, 32'h100, B0, 0, 32'h0);
    tbl[21] = v(0, 32'h0,   0, 0, 32'h0, 1,  0, 32'h100, 1, 32'h100, B0,    0, 32'h0);
    tbl[22] = v(1, 32'h102, 0, 0, 32'h0, 0,  1, 32'h104, 0, 32'h100, B0,    0, 32'h0);
    tbl[23] = v(0, 32'h0,   1, 0, 32'h0, 0,  0, 32'h0,   0, 32'h100, B0,    1, 32'h102);
    tbl[24] = v(1, 32'h200, 0, 0, 32'h0, 0,  0, 32'h0,   0, 32'h100, B0,    1, 32'h102);
    tbl[25] = v(0, 32'h0,   1, 0, 32'h0, 0,  1, 32'h200, 0, 32'h100, B0,    0, 32'h102);
    tbl[26] = v(0, 32'h0,   0, 1, C0,    0,  0, 32'h200, 0, 32'h100, B0,    0, 32'h102);
    tbl[27] = v(0, 32'h0,   0, 0, 32'h0, 1,  0, 32'h200, 1, 32'h200, C0,    0, 32'h102);
    tbl[28] = v(0, 32'h0,   0, 0, 32'h0, 0,  1, 32'h204, 0, 32'h200, C0,    0, 32'h102);

    #12;
    rst_chk("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("row%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("row%0d_ifv", i), {31'd0, if_valid}, {31'd0, tbl[i].e_ifv});
      chk($sformatf("row%0d_fault", i), {31'd0, fault}, {31'd0, tbl[i].e_flt});
      if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      if (tbl[i].e_ifv) begin
        chk($sformatf("row%0d_ifpc", i), if_pc, tbl[i].e_pc);
        chk($sformatf("row%0d_instr", i), if_instr, tbl[i].e_instr);
      end
      if (tbl[i].e_flt) chk($sformatf("row%0d_fpc", i), fault_pc, tbl[i].e_fpc);
      redirect_valid = tbl[i].rv;  redirect_target = tbl[i].tgt;
      imem_gnt = tbl[i].gnt;       imem_rvalid = tbl[i].rvl;
      imem_rdata = tbl[i].rd;      if_ready = tbl[i].rdy;
      step();
    end

    // Asynchronous reset asserted in the middle of a HOLD cycle
    drive_idle();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4444_0204;
    step();
    imem_rvalid = 1'b0;
    chk("midhold_ifv", {31'd0, if_valid}, 32'd1);
    chk("midhold_ifpc", if_pc, 32'h204);
    #2 rst = 1'b1;
    #1 rst_chk("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Randomized run: memory with 1..3 cycle latency, transaction-level PC model
    pend = 1'b0; paddr = 32'h0; cnt = 0; exp_pc = 32'h0; ntx = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_req_vs_ifv", {31'd0, imem_req & if_valid}, 32'd0);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = hsh(paddr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_gnt        = !pend && !imem_rvalid && ($urandom_range(0, 3) != 0);
      if_ready        = ($urandom_range(0, 2) != 0);
      redirect_valid  = ($urandom_range(0, 11) == 0);
      redirect_target = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) redirect_target = 32'hFFFF_FFF8;
      if (imem_req && imem_gnt) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = $urandom_range(0, 2);
      end
      xfer = if_valid && if_ready;
      if (xfer) begin
        chk("rnd_ifpc", if_pc, exp_pc);
        chk("rnd_instr", if_instr, hsh(exp_pc));
        ntx++;
      end
      if (redirect_valid) exp_pc = redirect_target;
      else if (xfer)      exp_pc = exp_pc + 32'd4;
      step();
    end
    drive_idle();
    chk("rnd_progress", {31'd0, ntx > 50}, 32'd1);
    chk("rnd_fault", {31'd0, fault}, 32'd0);

    // RESET_PC at the top of the address space: next fetch wraps to zero
    chk("wrap_rst_fpc", fpc2, 32'h0);
    rst2 = 1'b0;
    step();
    chk("wrap_req0", {31'd0, req2}, 32'd1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    gnt2 = 1'b1;
    step();
    gnt2 = 1'b0; rvalid2 = 1'b1; rdata2 = 32'h5555_AAAA;
    step();
    rvalid2 = 1'b0;
    chk("wrap_ifv", {31'd0, ifv2}, 32'd1);
    chk("wrap_ifpc", ifpc2, 32'hFFFF_FFFC);
    chk("wrap_instr", instr2, 32'h5555_AAAA);
    rdy2 = 1'b1;
    step();
    rdy2 = 1'b0;
    chk("wrap_req1", {31'd0, req2}, 32'd1);
    chk("wrap_addr1", addr2, 32'h0);
    chk("wrap_fault", {31'd0, fault2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the architectural fetch PC and sequences instruction-memory requests for the core. It issues one outstanding request at a time, holds each returned instruction until decode accepts it, and applies branch/jump redirects from execute, discarding any in-flight wrong-path response. It sits between the core's redirect source and the instruction memory port, feeding the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  redirect request from execute (branch taken / jump)
- redirect_target  in  32  redirect destination
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_gnt  in  1  memory accepts request this cycle (imem_req & imem_gnt)
- imem_rvalid  in  1  read data valid (exactly one per granted request, ≥1 cycle after grant)
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_pc  out  32  PC of if_instr
- if_instr  out  32  instruction word
- if_ready  in  1  decode accepts (transfer = if_valid & if_ready)
- fault  out  1  misaligned redirect trapped
- fault_pc  out  32  offending redirect target

## Operation
- Internal regs: pc[31:0], state, kill flag. Outputs registered.
- States: IDLE, REQ, WAIT, HOLD, FAULT. Reset state IDLE.
- IDLE: imem_req=0; next cycle -> REQ (pc unchanged, or pc=redirect_target if redirect_valid).
- REQ: imem_req=1, imem_addr=pc. On grant -> WAIT. Redirect without grant: pc=target, stay REQ (re-targeting before grant allowed). Redirect with grant: -> WAIT, kill=1, pc=target.
- WAIT: imem_req=0. On imem_rvalid: if kill (or redirect this cycle) drop data, clear kill, -> REQ at pc (target if redirect); else capture if_instr=imem_rdata, if_pc=pc -> HOLD. Redirect without rvalid: kill=1, pc=target.
- HOLD: if_valid=1. Transfer without redirect: pc=pc+4 -> REQ. Redirect (with or without transfer): pc=target -> REQ; a coincident transfer still counts as completed; held instr otherwise discarded (if_valid low next cycle).
- pc+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Any redirect with target[1:0]!=0: -> FAULT, fault=1, fault_pc=target, if_valid=0, imem_req=0, pending response (if WAIT) silently dropped. FAULT exits only via aligned redirect (-> REQ at target, fault cleared) or reset.
- imem_rvalid outside WAIT is ignored.

## Timing
- Reset (async assert): immediately imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=0, fault=0, fault_pc=0, kill=0, pc=RESET_PC.
- First imem_req at 2nd rising edge after rst deassert (IDLE one cycle).
- Zero-wait memory (gnt in REQ cycle, rvalid next cycle): if_valid rises the cycle after rvalid; one instruction per 3 cycles with if_ready held high.
- Redirect -> imem_addr=target on the next cycle (REQ), except while WAIT awaits the killed response.
- Reset mid-WAIT: outstanding response after reset must be ignored (arrives in IDLE/REQ, not WAIT... if it lands in WAIT after new grant it is the new request's—memory must flush on rst).

## Test plan
- Reset release, zero-wait memory, if_ready=1 -> imem_addr 0x0,0x4,0x8; if_pc/if_instr match each rdata; if_valid every 3rd cycle.
- imem_gnt held low 4 cycles -> imem_req and imem_addr=0x4 stable 4 cycles, advance only after grant.
- Redirect to 0x100 while WAIT on 0x8 -> 0x8 response dropped (no if_valid), next request 0x100, if_pc=0x100.
- if_ready low 5 cycles in HOLD -> if_valid, if_pc, if_instr stable; no imem_req until transfer.
- Redirect to 0x102 -> fault=1, fault_pc=0x102, no requests; then redirect to 0x200 -> fault=0, fetch 0x200.
- RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0; async rst asserted mid-HOLD -> outputs return to reset values before next edge.
